// File: rtl/accel_pkg.sv
// Shared definitions for the RAM-to-accelerator sample streamer.
package accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_PUSH,
    ST_FIN
  } state_t;

  localparam logic MODE_BCAST = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Pointer width that stays legal for a single-channel build.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ch_rr_pick.sv
// Round-robin channel picker: next set mask bit after ptr (cyclic) and lowest set bit.
// Purely combinational; an empty mask returns ptr unchanged and lowest=0.
module ch_rr_pick
  import accel_pkg::*;
#(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]        mask,
  input  logic [ptr_w(NUM_CH)-1:0] ptr,
  output logic [ptr_w(NUM_CH)-1:0] nxt,
  output logic [ptr_w(NUM_CH)-1:0] lowest
);

  localparam int PTR_W = ptr_w(NUM_CH);

  logic [PTR_W-1:0] cand;

  always_comb begin
    nxt    = ptr;
    lowest = '0;
    cand   = '0;
    // Descending scan so the closest candidate after ptr is the last one written.
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = PTR_W'((int'(ptr) + k) % NUM_CH);
      if (mask[cand]) nxt = cand;
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) lowest = PTR_W'(i);
    end
  end

endmodule

// File: rtl/accel_stream_ctrl.sv
// Streams a block of RAM words into NUM_CH accelerator FIFOs, broadcast or round-robin; 3 cycles/word minimum.
// Backpressure: holds ch_data and withholds ch_put while any targeted channel reports full; no timeout.
module accel_stream_ctrl
  import accel_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              ram_read_enable,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] ram_data_in,
  input  logic [NUM_CH-1:0] ch_full,
  output logic [NUM_CH-1:0] ch_put,
  output logic [DATA_W-1:0] ch_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_sent
);

  localparam int PTR_W = ptr_w(NUM_CH);

  state_t             state;
  logic               mode_q;
  logic [ADDR_W-1:0]  base_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   idx_inc;
  logic [NUM_CH-1:0]  mask_q;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [PTR_W-1:0]   ptr_low;
  logic [NUM_CH-1:0]  pick_mask;
  logic [NUM_CH-1:0]  put_sel;
  logic               put_ok;
  logic               put_fire;

  // In IDLE the picker looks at the incoming mask so the start pointer is ready on accept.
  assign pick_mask = (state == ST_IDLE) ? ch_mask : mask_q;
  assign idx_inc   = idx + LEN_W'(1);

  ch_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .mask   (pick_mask),
    .ptr    (ptr),
    .nxt    (ptr_next),
    .lowest (ptr_low)
  );

  always_comb begin
    put_sel = '0;
    put_ok  = 1'b0;
    if (mode_q == MODE_RR) begin
      put_sel = NUM_CH'(1) << ptr;
      put_ok  = ~ch_full[ptr];
    end else begin
      put_sel = mask_q;
      put_ok  = ((ch_full & mask_q) == '0);
    end
  end

  // Put is gated by this cycle's full flags and abort, so it cannot be registered.
  assign put_fire = (state == ST_PUSH) && put_ok && !abort && !reset;
  assign ch_put   = put_fire ? put_sel : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      ram_read_enable <= 1'b0;
      addr            <= '0;
      ch_data         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      words_sent      <= '0;
      mode_q          <= MODE_BCAST;
      base_q          <= '0;
      len_q           <= '0;
      idx             <= '0;
      mask_q          <= '0;
      ptr             <= '0;
    end else if (abort) begin
      state           <= ST_IDLE;
      ram_read_enable <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      ram_read_enable <= 1'b0;
      done            <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            words_sent <= '0;
            if (length != '0 && ch_mask != '0) begin
              mode_q          <= mode;
              base_q          <= base_addr;
              len_q           <= length;
              mask_q          <= ch_mask;
              idx             <= '0;
              ptr             <= ptr_low;
              busy            <= 1'b1;
              ram_read_enable <= 1'b1;
              addr            <= base_addr;
              state           <= ST_FETCH;
            end else begin
              done  <= 1'b1;
              state <= ST_FIN;
            end
          end
        end
        ST_FETCH: state <= ST_WAIT_RD;
        ST_WAIT_RD: begin
          ch_data <= ram_data_in;
          state   <= ST_PUSH;
        end
        ST_PUSH: begin
          if (put_ok) begin
            idx        <= idx_inc;
            words_sent <= words_sent + LEN_W'(1);
            if (mode_q == MODE_RR) ptr <= ptr_next;
            if (idx_inc == len_q) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              ram_read_enable <= 1'b1;
              addr            <= base_q + ADDR_W'(idx_inc);
              state           <= ST_FETCH;
            end
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_stream_ctrl.sv
// Directed bench for accel_stream_ctrl with a RAM model returning RAM[a]=a.
module tb_accel_stream_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int NUM_CH = 2;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              reset, start, abort, mode;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  length;
  logic [NUM_CH-1:0] ch_mask, ch_full, ch_put;
  logic              ram_read_enable;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] ram_data_in = '0;
  logic [DATA_W-1:0] ch_data;
  logic              busy, done;
  logic [LEN_W-1:0]  words_sent;

  int errors = 0;
  int checks = 0;

  // Activity log filled by the monitor; tasks compare against snapshots of its sizes.
  logic [NUM_CH-1:0] cur_mask;
  logic [31:0]       rd_q[$];
  logic [NUM_CH-1:0] put_q[$];
  logic [31:0]       dat_q[$];
  int                put_cyc_q[$];
  int                cyc = 0;
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                busy_rise = 0;
  int                viol = 0;
  logic              busy_d = 1'b0;

  always #5 clk = ~clk;

  accel_stream_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .length(length), .ch_mask(ch_mask),
    .ram_read_enable(ram_read_enable), .addr(addr), .ram_data_in(ram_data_in),
    .ch_full(ch_full), .ch_put(ch_put), .ch_data(ch_data),
    .busy(busy), .done(done), .words_sent(words_sent)
  );

  always @(posedge clk) if (ram_read_enable === 1'b1) ram_data_in <= addr;

  always @(negedge clk) begin
    cyc++;
    if (ram_read_enable === 1'b1) rd_q.push_back(addr);
    if (ch_put !== '0 && !$isunknown(ch_put)) begin
      put_q.push_back(ch_put);
      dat_q.push_back(ch_data);
      put_cyc_q.push_back(cyc);
      if ((ch_put & ch_full) != '0) viol++;
      if ((ch_put & ~cur_mask) != '0) viol++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1 && !busy_d) busy_rise = cyc;
    busy_d = (busy === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic m, input logic [31:0] b, input logic [15:0] l,
                        input logic [1:0] msk);
    mode = m; base_addr = b; length = l; ch_mask = msk; cur_mask = msk;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int i = 0; i < budget && done_cnt == d0; i++) step(1);
    step(2);
  endtask

  task automatic test_reset();
    step(3);
    checks++; if (ram_read_enable !== 1'b0) begin errors++; $display("FAIL rst_re: got %b want 0", ram_read_enable); end
    checks++; if (addr !== '0) begin errors++; $display("FAIL rst_addr: got %h want 0", addr); end
    checks++; if (ch_put !== '0) begin errors++; $display("FAIL rst_put: got %b want 00", ch_put); end
    checks++; if (ch_data !== '0) begin errors++; $display("FAIL rst_data: got %h want 0", ch_data); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", busy, done); end
    checks++; if (words_sent !== '0) begin errors++; $display("FAIL rst_words: got %0d want 0", words_sent); end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_broadcast();
    int r0 = rd_q.size(), p0 = put_q.size(), d0 = done_cnt, v0 = viol;
    launch(1'b0, 32'h10, 16'd4, 2'b11);
    wait_done(d0, 40);
    checks++; if (rd_q.size() - r0 != 4) begin errors++; $display("FAIL bc_nreads: got %0d want 4", rd_q.size() - r0); end
    checks++; if (put_q.size() - p0 != 4) begin errors++; $display("FAIL bc_nputs: got %0d want 4", put_q.size() - p0); end
    for (int i = 0; i < 4 && r0 + i < rd_q.size(); i++) begin
      checks++; if (rd_q[r0+i] !== 32'h10 + i) begin errors++; $display("FAIL bc_addr%0d: got %h want %h", i, rd_q[r0+i], 32'h10 + i); end
    end
    for (int i = 0; i < 4 && p0 + i < put_q.size(); i++) begin
      checks++; if (put_q[p0+i] !== 2'b11 || dat_q[p0+i] !== 32'h10 + i) begin
        errors++; $display("FAIL bc_put%0d: got %b/%h want 11/%h", i, put_q[p0+i], dat_q[p0+i], 32'h10 + i); end
      checks++; if (put_cyc_q[p0+i] - busy_rise != 2 + 3 * i) begin
        errors++; $display("FAIL bc_putcyc%0d: got %0d want %0d", i, put_cyc_q[p0+i] - busy_rise, 2 + 3 * i); end
    end
    checks++; if (done_cnt - d0 != 1 || done_cyc - busy_rise != 12) begin
      errors++; $display("FAIL bc_done: got %0d pulses at +%0d want 1 at +12", done_cnt - d0, done_cyc - busy_rise); end
    checks++; if (words_sent !== 16'd4 || busy !== 1'b0) begin errors++; $display("FAIL bc_end: got ws=%0d busy=%b want 4/0", words_sent, busy); end
    checks++; if (viol != v0) begin errors++; $display("FAIL bc_safety: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_round_robin();
    int p0 = put_q.size(), d0 = done_cnt, v0 = viol;
    logic [1:0] exp_put;
    launch(1'b1, 32'h40, 16'd5, 2'b11);
    wait_done(d0, 40);
    checks++; if (put_q.size() - p0 != 5) begin errors++; $display("FAIL rr_nputs: got %0d want 5", put_q.size() - p0); end
    for (int i = 0; i < 5 && p0 + i < put_q.size(); i++) begin
      exp_put = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (put_q[p0+i] !== exp_put || dat_q[p0+i] !== 32'h40 + i) begin
        errors++; $display("FAIL rr_put%0d: got %b/%h want %b/%h", i, put_q[p0+i], dat_q[p0+i], exp_put, 32'h40 + i); end
    end
    checks++; if (words_sent !== 16'd5) begin errors++; $display("FAIL rr_words: got %0d want 5", words_sent); end
    p0 = put_q.size(); d0 = done_cnt;
    launch(1'b1, 32'h60, 16'd3, 2'b10);
    wait_done(d0, 40);
    checks++; if (put_q.size() - p0 != 3) begin errors++; $display("FAIL rr1_nputs: got %0d want 3", put_q.size() - p0); end
    for (int i = 0; i < 3 && p0 + i < put_q.size(); i++) begin
      checks++; if (put_q[p0+i] !== 2'b10 || dat_q[p0+i] !== 32'h60 + i) begin
        errors++; $display("FAIL rr1_put%0d: got %b/%h want 10/%h", i, put_q[p0+i], dat_q[p0+i], 32'h60 + i); end
    end
    checks++; if (viol != v0) begin errors++; $display("FAIL rr_safety: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_backpressure();
    int p0 = put_q.size(), d0 = done_cnt, v0 = viol;
    launch(1'b0, 32'h20, 16'd4, 2'b11);
    step(5);
    ch_full = 2'b10;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++; if (ch_put !== 2'b00 || ch_data !== 32'h21) begin
        errors++; $display("FAIL bp_stall%0d: got %b/%h want 00/00000021", k, ch_put, ch_data); end
      step(1);
    end
    ch_full = 2'b00;
    @(negedge clk);
    checks++; if (ch_put !== 2'b11 || ch_data !== 32'h21) begin errors++; $display("FAIL bp_release: got %b/%h want 11/00000021", ch_put, ch_data); end
    step(1);
    wait_done(d0, 40);
    checks++; if (put_q.size() - p0 != 4) begin errors++; $display("FAIL bp_nputs: got %0d want 4", put_q.size() - p0); end
    checks++; if (put_q.size() - p0 >= 2 && put_cyc_q[p0+1] - busy_rise != 12) begin
      errors++; $display("FAIL bp_putcyc: got %0d want 12", put_cyc_q[p0+1] - busy_rise); end
    checks++; if (done_cyc - busy_rise != 19 || words_sent !== 16'd4) begin
      errors++; $display("FAIL bp_done: got +%0d ws=%0d want +19 ws=4", done_cyc - busy_rise, words_sent); end
    checks++; if (viol != v0) begin errors++; $display("FAIL bp_safety: got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_degenerate(input logic [15:0] l, input logic [1:0] msk);
    int r0 = rd_q.size(), p0 = put_q.size(), d0 = done_cnt;
    launch(1'b0, 32'h50, l, msk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL deg_done_l%0d_m%b: got %b want 1", l, msk, done); end
    step(4);
    checks++; if (done_cnt - d0 != 1 || rd_q.size() != r0 || put_q.size() != p0 || busy !== 1'b0) begin
      errors++; $display("FAIL deg_quiet_l%0d_m%b: got done=%0d reads=%0d puts=%0d busy=%b want 1/0/0/0",
                         l, msk, done_cnt - d0, rd_q.size() - r0, put_q.size() - p0, busy); end
  endtask

  task automatic test_wrap();
    int r0 = rd_q.size(), p0 = put_q.size(), d0 = done_cnt;
    logic [31:0] exp_a;
    launch(1'b0, 32'hFFFF_FFFE, 16'd4, 2'b11);
    wait_done(d0, 40);
    checks++; if (rd_q.size() - r0 != 4 || put_q.size() - p0 != 4) begin
      errors++; $display("FAIL wrap_count: got %0d reads %0d puts want 4/4", rd_q.size() - r0, put_q.size() - p0); end
    for (int i = 0; i < 4 && r0 + i < rd_q.size() && p0 + i < put_q.size(); i++) begin
      exp_a = 32'hFFFF_FFFE + i;
      checks++; if (rd_q[r0+i] !== exp_a || dat_q[p0+i] !== exp_a) begin
        errors++; $display("FAIL wrap%0d: got addr %h data %h want %h", i, rd_q[r0+i], dat_q[p0+i], exp_a); end
    end
  endtask

  task automatic test_abort();
    int r0 = rd_q.size(), p0 = put_q.size(), d0 = done_cnt;
    launch(1'b0, 32'h80, 16'd8, 2'b11);
    step(8);
    abort = 1'b1;
    @(negedge clk);
    checks++; if (ch_put !== 2'b00) begin errors++; $display("FAIL abort_put: got %b want 00", ch_put); end
    step(1);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || ram_read_enable !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_outs: got busy=%b re=%b done=%b want 000", busy, ram_read_enable, done); end
    checks++; if (words_sent !== 16'd2) begin errors++; $display("FAIL abort_words: got %0d want 2", words_sent); end
    step(10);
    checks++; if (done_cnt != d0 || put_q.size() - p0 != 2 || rd_q.size() - r0 != 3) begin
      errors++; $display("FAIL abort_after: got done=%0d puts=%0d reads=%0d want 0/2/3",
                         done_cnt - d0, put_q.size() - p0, rd_q.size() - r0); end
  endtask

  task automatic test_reset_mid();
    int r0;
    launch(1'b0, 32'h80, 16'd8, 2'b11);
    step(5);
    checks++; if (words_sent !== 16'd1 || ch_data !== 32'h81) begin
      errors++; $display("FAIL rmid_pre: got ws=%0d data=%h want 1/00000081", words_sent, ch_data); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (ch_put !== 2'b00) begin errors++; $display("FAIL rmid_put: got %b want 00", ch_put); end
    step(1);
    reset = 1'b0;
    checks++; if (ram_read_enable !== 1'b0 || addr !== '0 || ch_data !== '0 || busy !== 1'b0 || done !== 1'b0 || words_sent !== '0) begin
      errors++; $display("FAIL rmid_outs: got re=%b addr=%h data=%h busy=%b done=%b ws=%0d want all 0",
                         ram_read_enable, addr, ch_data, busy, done, words_sent); end
    r0 = rd_q.size();
    step(5);
    checks++; if (rd_q.size() != r0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %0d reads busy=%b want 0/0", rd_q.size() - r0, busy); end
  endtask

  task automatic test_start_busy();
    int r0 = rd_q.size(), p0 = put_q.size(), d0 = done_cnt;
    launch(1'b0, 32'h10, 16'd4, 2'b11);
    step(3);
    mode = 1'b1; base_addr = 32'h99; length = 16'd1; ch_mask = 2'b01;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(d0, 40);
    checks++; if (rd_q.size() - r0 != 4 || put_q.size() - p0 != 4 || words_sent !== 16'd4) begin
      errors++; $display("FAIL sb_counts: got reads=%0d puts=%0d ws=%0d want 4/4/4", rd_q.size() - r0, put_q.size() - p0, words_sent); end
    for (int i = 0; i < 4 && p0 + i < put_q.size(); i++) begin
      checks++; if (put_q[p0+i] !== 2'b11 || dat_q[p0+i] !== 32'h10 + i) begin
        errors++; $display("FAIL sb_put%0d: got %b/%h want 11/%h", i, put_q[p0+i], dat_q[p0+i], 32'h10 + i); end
    end
    checks++; if (done_cnt - d0 != 1 || done_cyc - busy_rise != 12) begin
      errors++; $display("FAIL sb_done: got %0d pulses at +%0d want 1 at +12", done_cnt - d0, done_cyc - busy_rise); end
  endtask

  task automatic test_start_abort_idle();
    int r0 = rd_q.size(), p0 = put_q.size(), d0 = done_cnt;
    mode = 1'b0; base_addr = 32'h30; length = 16'd2; ch_mask = 2'b11;
    start = 1'b1; abort = 1'b1;
    step(1);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0 || ram_read_enable !== 1'b0) begin errors++; $display("FAIL sa_next: got busy=%b re=%b want 0/0", busy, ram_read_enable); end
    step(6);
    checks++; if (rd_q.size() != r0 || put_q.size() != p0 || done_cnt != d0 || words_sent !== 16'd4) begin
      errors++; $display("FAIL sa_quiet: got reads=%0d puts=%0d done=%0d ws=%0d want 0/0/0/4",
                         rd_q.size() - r0, put_q.size() - p0, done_cnt - d0, words_sent); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    base_addr = '0; length = '0; ch_mask = '0; ch_full = '0; cur_mask = '0;
    test_reset();
    test_broadcast();
    test_round_robin();
    test_backpressure();
    test_degenerate(16'd0, 2'b11);
    test_degenerate(16'd4, 2'b00);
    test_wrap();
    test_abort();
    test_reset_mid();
    test_start_busy();
    test_start_abort_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
